// File: rtl/mac_pe_sequencer.sv
// Sequences one signed weight/activation vector into a MAC PE, runs its accumulate phase, then captures and offers the result.
// Latency: last beat at T -> pe_acc at T+1, ACC T+1..T+8, capture at T+9, res_valid from T+10.
// Backpressure: result held in HOLD until res_ready; no new beats are accepted outside STREAM.
module mac_pe_sequencer #(
    parameter int RES_W = 21,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [3:0]       in_weight,
    input  logic signed [7:0]       in_act,
    input  logic                    in_last,
    output logic                    pe_en,
    output logic                    pe_data_valid,
    output logic signed [3:0]       pe_weight,
    output logic signed [7:0]       pe_activation,
    output logic                    pe_acc,
    output logic                    pe_reset,
    input  logic                    pe_output_valid,
    input  logic signed [RES_W-1:0] pe_output_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [RES_W-1:0] res_data,
    output logic [CNT_W-1:0]        res_count,
    output logic                    err
);

    typedef enum logic [2:0] {CLEAR, STREAM, ACC, WAIT, HOLD} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       acc_cnt_q;
    logic [CNT_W-1:0] pair_cnt_q;
    logic [CNT_W-1:0] pair_inc;
    logic             beat_xfer;

    assign pe_weight     = in_weight;
    assign pe_activation = in_act;
    assign pe_en         = ~rst;
    assign beat_xfer     = in_valid & in_ready;
    assign pe_data_valid = beat_xfer;
    // Pair counter sticks at all-ones rather than wrapping.
    assign pair_inc      = (&pair_cnt_q) ? pair_cnt_q : pair_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        pe_reset  = 1'b0;
        pe_acc    = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            CLEAR: begin
                pe_reset = 1'b1;
                state_d  = STREAM;
            end
            STREAM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                pe_acc = (acc_cnt_q == 3'd0);
                if (acc_cnt_q == 3'd7) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
        // Reset must silence every strobe in the same cycle, not one cycle later.
        if (rst) begin
            in_ready  = 1'b0;
            pe_reset  = 1'b0;
            pe_acc    = 1'b0;
            res_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt_q <= '0;
            acc_cnt_q  <= '0;
            res_data   <= '0;
            res_count  <= '0;
            err        <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    pair_cnt_q <= '0;
                    acc_cnt_q  <= '0;
                end
                STREAM: begin
                    if (beat_xfer) begin
                        if (in_last) begin
                            res_count  <= pair_inc;
                            pair_cnt_q <= '0;
                        end else begin
                            pair_cnt_q <= pair_inc;
                        end
                    end
                end
                ACC: begin
                    acc_cnt_q <= acc_cnt_q + 3'd1;
                end
                WAIT: begin
                    // Capture unconditionally; a missing PE valid only flags the error.
                    res_data <= pe_output_result;
                    if (!pe_output_valid) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_pe_sequencer.sv
// Randomized bench for mac_pe_sequencer: a time-based reference model predicts every strobe per cycle,
// a scoreboard queue holds expected results and a separate monitor checks them at the result handshake.
module tb_mac_pe_sequencer;

    localparam int RES_W = 21;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [3:0]       in_weight = '0;
    logic signed [7:0]       in_act = '0;
    logic                    in_last = 1'b0;
    logic                    pe_en;
    logic                    pe_data_valid;
    logic signed [3:0]       pe_weight;
    logic signed [7:0]       pe_activation;
    logic                    pe_acc;
    logic                    pe_reset;
    logic                    pe_output_valid = 1'b0;
    logic signed [RES_W-1:0] pe_output_result = '0;
    logic                    res_valid;
    logic                    res_ready = 1'b0;
    logic signed [RES_W-1:0] res_data;
    logic [CNT_W-1:0]        res_count;
    logic                    err;

    mac_pe_sequencer #(.RES_W(RES_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_weight(in_weight), .in_act(in_act), .in_last(in_last),
        .pe_en(pe_en), .pe_data_valid(pe_data_valid), .pe_weight(pe_weight), .pe_activation(pe_activation),
        .pe_acc(pe_acc), .pe_reset(pe_reset),
        .pe_output_valid(pe_output_valid), .pe_output_result(pe_output_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_count(res_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [3:0] w;
        logic signed [7:0] a;
        logic              last;
    } beat_t;

    typedef struct {
        int                      cnt;
        logic signed [RES_W-1:0] data;
    } exp_t;

    beat_t beats[$];
    exp_t  sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_clear = -1000;
    int t_last = -1000;
    bit busy = 1'b0;
    int cnt = 0;
    int dot = 0;
    int vec_cnt = 0;
    int vec_dot = 0;
    bit exp_err = 1'b0;
    bit miss_pe = 1'b0;
    int bp_len = 0;
    int done_cnt = 0;
    bit chk_zero = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Driver: beats from the queue, stray traffic outside the streaming window, PE model response.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (beats.size() > 0) begin
            in_valid  = ($urandom % 4) != 0;
            in_weight = beats[0].w;
            in_act    = beats[0].a;
            in_last   = beats[0].last;
        end else begin
            in_valid  = !(!busy && cyc > t_clear) && 1'($urandom);
            in_weight = 4'($urandom);
            in_act    = 8'($urandom);
            in_last   = 1'($urandom);
        end
        res_ready = busy ? (cyc >= t_last + 10 + bp_len) : 1'($urandom);
        if (busy && cyc == t_last + 9) begin
            pe_output_result = vec_dot[RES_W-1:0];
            pe_output_valid  = !miss_pe;
        end else begin
            pe_output_result = RES_W'($urandom);
            pe_output_valid  = 1'($urandom);
        end
    end

    // Reference model: expected strobes derived from the time of the last transfer and of the handshake.
    always @(negedge clk) begin
        bit er;
        bit pdv;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_pe_en", pe_en, 0);
            chk("rst_pe_acc", pe_acc, 0);
            chk("rst_pe_reset", pe_reset, 0);
            chk("rst_pe_data_valid", pe_data_valid, 0);
            chk("rst_res_valid", res_valid, 0);
            t_clear  = cyc + 1;
            busy     = 1'b0;
            cnt      = 0;
            dot      = 0;
            exp_err  = 1'b0;
            chk_zero = 1'b1;
            sb.delete();
            beats.delete();
        end else begin
            er  = !busy && cyc > t_clear;
            pdv = in_valid && er;
            chk("in_ready", in_ready, er);
            chk("pe_data_valid", pe_data_valid, pdv);
            chk("pe_reset", pe_reset, cyc == t_clear);
            chk("pe_acc", pe_acc, busy && cyc == t_last + 1);
            chk("res_valid", res_valid, busy && cyc >= t_last + 10);
            chk("pe_en", pe_en, 1);
            chk("err", err, exp_err);
            if (chk_zero) begin
                chk("post_rst_res_data", res_data, 0);
                chk("post_rst_res_count", res_count, 0);
                chk_zero = 1'b0;
            end
            if (pdv) begin
                cnt = (cnt >= CMAX) ? CMAX : cnt + 1;
                dot += int'(in_weight) * int'(in_act);
                void'(beats.pop_front());
                if (in_last) begin
                    t_last  = cyc;
                    busy    = 1'b1;
                    vec_cnt = cnt;
                    vec_dot = dot;
                    cnt     = 0;
                    dot     = 0;
                end
            end
            if (busy && cyc == t_last + 9) begin
                sb.push_back('{vec_cnt, RES_W'(vec_dot)});
                if (miss_pe) exp_err = 1'b1;
            end
            if (busy && cyc >= t_last + 10 && res_ready) begin
                busy    = 1'b0;
                t_clear = cyc + 1;
                done_cnt++;
            end
        end
    end

    // Monitor: compares the presented result against the scoreboard head, pops on handshake.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty res_valid=1 with no expected result cyc=%0d", cyc);
            end else begin
                chk("res_count", res_count, sb[0].cnt);
                chk("res_data", res_data, sb[0].data);
                if (res_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic push(input int w, input int a, input bit last);
        beats.push_back('{4'(w), 8'(a), last});
    endtask

    task automatic push_rand(input int len);
        for (int i = 0; i < len; i++) push(int'($urandom), int'($urandom), i == len - 1);
    endtask

    task automatic wait_done(input int n0);
        int k = 0;
        while (done_cnt == n0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (done_cnt == n0) begin
            failures++;
            $display("FAIL vector_timeout no result handshake cyc=%0d", cyc);
        end
    endtask

    task automatic do_rst();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int n0;
        int k;
        #500000;
        $display("FAIL watchdog simulation did not finish cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int k;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // 3-pair vector
        bp_len = 0; n0 = done_cnt;
        push(1, 10, 0); push(-2, 5, 0); push(3, -4, 1);
        wait_done(n0);

        // back-pressure for 5 HOLD cycles
        bp_len = 5; n0 = done_cnt;
        push_rand(4);
        wait_done(n0);

        // single beat, weight 0
        bp_len = 1; n0 = done_cnt;
        push(0, int'($urandom), 1);
        wait_done(n0);

        // missing PE valid, error must survive later vectors
        miss_pe = 1'b1; bp_len = 0; n0 = done_cnt;
        push_rand(2);
        wait_done(n0);
        miss_pe = 1'b0;
        for (int v = 0; v < 2; v++) begin
            n0 = done_cnt; bp_len = v;
            push_rand(3);
            wait_done(n0);
        end
        do_rst();

        // counter saturation
        bp_len = 2; n0 = done_cnt;
        push_rand(20);
        wait_done(n0);

        // reset in the 4th ACC cycle aborts the vector
        bp_len = 0;
        push_rand(3);
        k = 0;
        while (!(busy && cyc == t_last + 4) && k < 400) begin
            @(posedge clk);
            #2;
            k++;
        end
        checks++;
        if (!(busy && cyc == t_last + 4)) begin
            failures++;
            $display("FAIL mid_acc_reach never reached ACC cycle 4 cyc=%0d", cyc);
        end
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;

        // randomized vectors
        for (int v = 0; v < 25; v++) begin
            n0 = done_cnt;
            bp_len  = int'($urandom_range(0, 3));
            miss_pe = ($urandom % 8) == 0;
            push_rand(int'($urandom_range(1, 6)));
            wait_done(n0);
            miss_pe = 1'b0;
        end

        repeat (5) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
